// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider (fp_Z = fp_X / fp_Y), radix-2 restoring,
// one quotient bit per cycle, fixed latency, start/busy/done handshake.
module fp_div_seq #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  r_mode,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic [1:0]  dbg_state_o
);
  // Handshake: start is sampled only in IDLE outside the done cycle; busy is high for the
  // QBITS divide cycles; done pulses for one cycle with fp_Z/ovrf/udrf, which then hold.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_RND = 2'd2} state_t;
  typedef enum logic [1:0] {C_NORM = 2'd0, C_NAN = 2'd1, C_INF = 2'd2, C_ZERO = 2'd3} cls_t;
  localparam int CW = $clog2(QBITS);

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [24:0]       r_q, r_d;
  logic [QBITS-2:0]  q_q, q_d;
  logic [23:0]       my_q, my_d;
  logic signed [9:0] e_q, e_d;
  logic              sign_q, sign_d;
  logic [2:0]        rm_q, rm_d;
  logic [31:0]       z_q, z_d;
  logic              ovrf_q, ovrf_d, udrf_q, udrf_d, done_q, done_d;

  logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic [23:0]       mx, my, diff;
  logic              m_lt, r_ge;
  logic              lsb, g, rb, st, inexact, inc, carry;
  logic [22:0]       frac;
  logic signed [9:0] e_r;

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    my_d    = my_q;
    e_d     = e_q;
    sign_d  = sign_q;
    rm_d    = rm_q;
    z_d     = z_q;
    ovrf_d  = ovrf_q;
    udrf_d  = udrf_q;
    done_d  = 1'b0;

    x_zero = (fp_X[30:23] == 8'd0);
    y_zero = (fp_Y[30:23] == 8'd0);
    x_inf  = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] == 23'd0);
    y_inf  = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] == 23'd0);
    x_nan  = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] != 23'd0);
    y_nan  = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] != 23'd0);
    mx     = {1'b1, fp_X[22:0]};
    my     = {1'b1, fp_Y[22:0]};
    m_lt   = (mx < my);

    // Partial remainder stays below 2*mY, so the difference always fits 24 bits.
    r_ge = (r_q >= {1'b0, my_q});
    diff = r_q[23:0] - my_q;

    // The leading quotient bit (always 1) has been shifted out of q_q.
    lsb     = q_q[QBITS-24];
    g       = q_q[QBITS-25];
    rb      = q_q[QBITS-26];
    st      = |r_q;
    inexact = g | rb | st;
    case (rm_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign_q & inexact;
      3'b011:  inc = ~sign_q & inexact;
      3'b100:  inc = g;
      default: inc = g & (rb | st | lsb);
    endcase
    {carry, frac} = {1'b0, q_q[QBITS-2 -: 23]} + {23'd0, inc};
    e_r = e_q + {9'd0, carry};

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          sign_d = fp_X[31] ^ fp_Y[31];
          rm_d   = r_mode;
          if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) cls_d = C_NAN;
          else if (x_inf || y_zero)                                    cls_d = C_INF;
          else if (x_zero || y_inf)                                    cls_d = C_ZERO;
          else                                                         cls_d = C_NORM;
          my_d    = my;
          r_d     = m_lt ? {mx, 1'b0} : {1'b0, mx};
          e_d     = {2'b00, fp_X[30:23]} - {2'b00, fp_Y[30:23]} + 10'd127 - {9'd0, m_lt};
          q_d     = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        r_d   = r_ge ? {diff, 1'b0} : {r_q[23:0], 1'b0};
        q_d   = {q_q[QBITS-3:0], r_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QBITS - 1)) state_d = S_RND;
      end
      S_RND: begin
        done_d  = 1'b1;
        ovrf_d  = 1'b0;
        udrf_d  = 1'b0;
        state_d = S_IDLE;
        case (cls_q)
          C_NAN:  z_d = 32'h7FC0_0000;
          C_INF:  z_d = {sign_q, 8'hFF, 23'd0};
          C_ZERO: z_d = {sign_q, 31'd0};
          default: begin
            if (e_r >= 10'sd255) begin
              z_d    = {sign_q, 8'hFF, 23'd0};
              ovrf_d = 1'b1;
            end else if (e_r <= 10'sd0) begin
              z_d    = {sign_q, 31'd0};
              udrf_d = 1'b1;
            end else begin
              z_d = {sign_q, e_r[7:0], frac};
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_NORM;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      my_q    <= '0;
      e_q     <= '0;
      sign_q  <= 1'b0;
      rm_q    <= 3'd0;
      z_q     <= 32'd0;
      ovrf_q  <= 1'b0;
      udrf_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      my_q    <= my_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      rm_q    <= rm_d;
      z_q     <= z_d;
      ovrf_q  <= ovrf_d;
      udrf_q  <= udrf_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == S_DIV);
  assign done        = done_q;
  assign fp_Z        = z_q;
  assign ovrf        = ovrf_q;
  assign udrf        = udrf_q;
  assign dbg_state_o = state_q;
endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Sequential IEEE-754 single-precision divider, fp_Z = fp_X / fp_Y. It is the inverse-operation companion to the team's combinational FP multiplier.
- Uses the same r_mode encoding, the same ovrf/udrf flags and the same special-value policy, so both units can share one FPU result path.
- Computes one quotient bit per cycle with a radix-2 restoring mantissa divider.
- Uses a start/busy/done handshake and a fixed latency.

Parameters:
- QBITS, 26, quotient bits generated: 24 significand bits plus guard and round. Sticky comes from the final remainder.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operation request; sampled only while idle
- r_mode  input  3  rounding mode: 000 RNE, 001 RTZ, 010 toward -inf, 011 toward +inf, 100 nearest-ties-away; 101-111 treated as RNE
- fp_X  input  32  dividend
- fp_Y  input  32  divisor
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when fp_Z and the flags are valid
- fp_Z  output  32  quotient; held until the next accepted start
- ovrf  output  1  overflow flag, valid with done, held alongside fp_Z
- udrf  output  1  underflow flag, same timing as ovrf

Behaviour:
- Reset: one clock, asynchronous active-low reset rst_n. While rst_n is low, state=IDLE and busy, done, fp_Z, ovrf, udrf are all 0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE -> DIV -> RND -> IDLE.
- IDLE, start=1:
  - Latch sign = X[31]^Y[31], r_mode, and the special-case class.
  - Form mantissas mX = {1,frcX} and mY = {1,frcY} (24 bits each).
  - Form exponent e = expX - expY + 127 as a signed 10-bit value.
  - If mX < mY, shift the dividend left 1 and decrement e, so the quotient lies in [1,2).
  - Clear the counter and go to DIV.
- DIV: QBITS cycles, one per quotient bit.
  - Trial r - mY. If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - r <<= 1 each cycle.
  - After QBITS cycles go to RND.
- RND (1 cycle):
  - sticky = (remainder != 0).
  - Round the 24-bit significand using guard/round/sticky, sign and r_mode.
  - A carry-out sets the significand to 1.0 and increments e.
  - Register fp_Z, ovrf, udrf; pulse done; return to IDLE.
- Latency: start accepted at cycle N -> done=1 at cycle N+QBITS+1 (N+27 by default), for all operand classes. Specials still traverse DIV with a forced result.
- start while busy or during the done cycle is ignored. A new start is accepted in the cycle after done.
- Operands are captured at start; fp_X, fp_Y and r_mode may change afterwards without effect.
- Special cases (priority order):
  - Either operand NaN, 0/0, or inf/inf -> fp_Z = 0x7FC00000, flags 0.
  - inf/x or x/0 (x nonzero) -> signed infinity, flags 0.
  - 0/x or x/inf -> signed zero, flags 0.
- Subnormal inputs (exp=0) are treated as signed zero.
- Range after rounding:
  - e >= 255 -> signed infinity, ovrf=1.
  - e <= 0 -> signed zero, udrf=1; no subnormal outputs are produced.
- ovrf and udrf are never both 1.

Test Plan:
- Basic quotient: 0x40C00000 / 0x40000000 (6/2), RNE -> done at start+27, fp_Z=0x40400000, ovrf=udrf=0; busy high for exactly 26 cycles before done.
- Rounding: 0x3F800000 / 0x40400000 (1/3).
  - RNE -> 0x3EAAAAAB.
  - RTZ -> 0x3EAAAAAA.
  - Toward +inf -> 0x3EAAAAAB.
  - Negated dividend, toward -inf -> 0xBEAAAAAB.
- Specials, each checked with the fixed latency:
  - 0x3F800000 / 0x00000000 -> 0x7F800000.
  - 0x00000000 / 0x00000000 -> 0x7FC00000.
  - 0x7F800000 / 0xC0000000 -> 0xFF800000.
- Range:
  - 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, ovrf=1.
  - 0x00800000 / 0x40000000 -> 0x00000000, udrf=1.
- Handshake: pulse start again 5 cycles after acceptance with different operands -> ignored, first result unchanged. start in the cycle after done -> accepted.
- Reset: assert rst_n=0 at DIV cycle 10 -> busy, done, fp_Z, flags go to 0 immediately; no done follows. A new operation after release completes normally.
